reg_write_arbiter: RTL

Owns the single write port of the 32x32 register file and shares it between two writeback requesters: REQ0 (ALU result) and REQ1 (memory load). It also runs a clear sequence that zeroes every register through the same port, so clearing no longer needs a separate mechanism. The block sits between the writeback stage and the register file, and drives the register file's WRITE, INADDRESS and IN inputs.

---
 rtl/reg_write_arbiter_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr.sv | 41 ++++
 rtl/reg_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg
// Shared definitions for the register-file write arbiter:
//   - state_t   : arbiter FSM encoding (ARB = normal grants, CLEAR = zeroing sweep)
//   - NUM_REGS, ADDR_WIDTH, DATA_WIDTH : default geometry of the register file
package reg_write_arbiter_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// rr_arbiter2
// Two-way round-robin grant with combinational grant outputs.
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   asynchronous active-low reset (pointer returns to requester 0)
//   valid  in   [1:0] request lines
//   block  in   forces both grants low
//   grant  out  [1:0] one-hot (or zero) grant, never set without its valid
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] valid,
  input  logic       block,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    if (!block) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant always implies a transfer, so the pointer moves to the
  // requester that was not served.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr <= 1'b0;
    end else if (|grant) begin
      rr_ptr <= grant[0];
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Owns the register file write port. Shares it between REQ0 (ALU) and REQ1
// (load) with round-robin arbitration, and runs a sweep that writes zero to
// every register when CLEAR_REQ is seen.
// Ports:
//   CLK, RESET                         clock / async active-low reset
//   REQn_VALID, REQn_ADDR, REQn_DATA   requester n write request
//   REQn_READY                         requester n granted (combinational)
//   CLEAR_REQ                          level request for a clear sweep
//   CLEAR_BUSY                         sweep in progress (registered)
//   CLEAR_DONE                         one-cycle pulse on the last sweep write
//   WRITE, INADDRESS, IN               registered register-file write port
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REGS   = reg_write_arbiter_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = reg_write_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = reg_write_arbiter_pkg::DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA,
  output logic                  REQ1_READY,
  input  logic                  CLEAR_REQ,
  output logic                  CLEAR_BUSY,
  output logic                  CLEAR_DONE,
  output logic                  WRITE,
  output logic [ADDR_WIDTH-1:0] INADDRESS,
  output logic [DATA_WIDTH-1:0] IN
);

  // One extra bit so the terminal compare cannot wrap for NUM_REGS = 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(NUM_REGS - 1);

  state_t                state;
  logic   [ADDR_WIDTH:0] counter;
  logic   [1:0]          grant;
  logic                  block;

  // Grants are suppressed during reset, while a clear is requested, and
  // for the whole sweep.
  assign block = !RESET || CLEAR_REQ || (state == CLEAR);

  rr_arbiter2 u_rr (
    .CLK   (CLK),
    .RESET (RESET),
    .valid ({REQ1_VALID, REQ0_VALID}),
    .block (block),
    .grant (grant)
  );

  assign REQ0_READY = grant[0];
  assign REQ1_READY = grant[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ARB;
      counter    <= '0;
      WRITE      <= 1'b0;
      INADDRESS  <= '0;
      IN         <= '0;
      CLEAR_BUSY <= 1'b0;
      CLEAR_DONE <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          CLEAR_DONE <= 1'b0;
          if (CLEAR_REQ) begin
            state      <= CLEAR;
            counter    <= '0;
            CLEAR_BUSY <= 1'b1;
            WRITE      <= 1'b0;
          end else if (grant[0]) begin
            WRITE     <= 1'b1;
            INADDRESS <= REQ0_ADDR;
            IN        <= REQ0_DATA;
          end else if (grant[1]) begin
            WRITE     <= 1'b1;
            INADDRESS <= REQ1_ADDR;
            IN        <= REQ1_DATA;
          end else begin
            WRITE <= 1'b0;
          end
        end
        CLEAR: begin
          WRITE     <= 1'b1;
          INADDRESS <= counter[ADDR_WIDTH-1:0];
          IN        <= '0;
          counter   <= counter + 1'b1;
          if (counter == CNT_LAST) begin
            state      <= ARB;
            CLEAR_BUSY <= 1'b0;
            CLEAR_DONE <= 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
